wide_add_sequencer: RTL and testbench

WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

---
 rtl/wide_add_pkg.sv | 13 +
 rtl/add_byte_slice.sv | 23 ++
 rtl/wide_add_sequencer.sv | 128 ++++++++++++
 tb/tb_wide_add_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and constants for the byte-serial wide adder.
package wide_add_pkg;

    localparam int BYTE_W     = 8;
    localparam int NBYTES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_byte_slice.sv
// One 8-bit ripple slice. It also exposes the carry into bit 7 so the top
// level can form signed overflow.
module add_byte_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       c7
);

    logic [7:0] w_lo;
    logic [1:0] w_hi;

    // The low 7 bits are added separately so the carry into the MSB is visible.
    assign w_lo = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'b0, cin};
    assign w_hi = {1'b0, a[7]} + {1'b0, b[7]} + {1'b0, w_lo[7]};

    assign sum  = {w_hi[0], w_lo[6:0]};
    assign c7   = w_lo[7];
    assign cout = w_hi[1];

endmodule

// File: rtl/wide_add_sequencer.sv
// Byte-serial add/subtract of two NBYTES-wide operands. The operands pass
// through one 8-bit slice, least significant byte first.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                     in_cin,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_sum,
    output logic                     out_cout,
    output logic                     out_zero,
    output logic                     out_ovf,
    output logic                     busy
);

    localparam int W    = BYTE_W * NBYTES;
    localparam int IDXW = $clog2(NBYTES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDXW-1:0]   r_idx;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_sum;
    logic              r_sub;
    logic              r_carry;
    logic              r_cout;
    logic              r_zero;
    logic              r_ovf;

    logic [W-1:0]      w_sum_nxt;
    logic [BYTE_W-1:0] w_a_byte;
    logic [BYTE_W-1:0] w_b_byte;
    logic [BYTE_W-1:0] w_s_byte;
    logic              w_co;
    logic              w_c7;
    logic              w_accept;
    logic              w_last;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_idx == IDXW'(NBYTES - 1));
    assign w_a_byte = r_a[r_idx*BYTE_W +: BYTE_W];
    // Subtraction is a + ~b + 1. The +1 is supplied by the initial carry.
    assign w_b_byte = r_sub ? ~r_b[r_idx*BYTE_W +: BYTE_W]
                            :  r_b[r_idx*BYTE_W +: BYTE_W];

    add_byte_slice u_slice (
        .a    (w_a_byte),
        .b    (w_b_byte),
        .cin  (r_carry),
        .sum  (w_s_byte),
        .cout (w_co),
        .c7   (w_c7)
    );

    always_comb begin
        w_sum_nxt = r_sum;
        w_sum_nxt[r_idx*BYTE_W +: BYTE_W] = w_s_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_sub   <= in_sub;
            r_carry <= in_sub | in_cin;
            r_idx   <= '0;
            r_sum   <= '0;
        end else if (r_state == ST_RUN) begin
            r_sum   <= w_sum_nxt;
            r_carry <= w_co;
            // The index stops at the last byte, so it never wraps.
            if (w_last) begin
                r_cout <= w_co;
                r_zero <= (w_sum_nxt == '0);
                r_ovf  <= w_c7 ^ w_co;
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_zero  = r_zero;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed scoreboard bench for wide_add_sequencer with NBYTES=4.
module tb_wide_add_sequencer;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        zero;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_zero;
    logic        out_ovf;
    logic        busy;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    wide_add_sequencer #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare at the falling edge before each output handshake edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got result %h expected none", out_sum);
            end else begin
                mon_e = sb.pop_front();
                chk("sum",  out_sum,         mon_e.sum);
                chk("cout", {31'b0, out_cout}, {31'b0, mon_e.cout});
                chk("zero", {31'b0, out_zero}, {31'b0, mon_e.zero});
                chk("ovf",  {31'b0, out_ovf},  {31'b0, mon_e.ovf});
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input logic [31:0] es, input logic ec,
                        input logic ez, input logic eo, input bit push);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        if (push) sb.push_back('{sum: es, cout: ec, zero: ez, ovf: eo});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        in_sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  {31'b0, busy},      32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum",   out_sum,            32'd0);
        chk("rst_flags", {29'b0, out_cout, out_zero, out_ovf}, 32'd0);
        rst = 1'b0;
        chk("rst_ready", {31'b0, in_ready},  32'd1);

        // all-ones plus one: wraps to zero, carry out
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_valid(n);
        chk("latency", n, 32'd4);
        @(posedge clk); #1;

        // 5 - 7 with cin=1, which must be ignored
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid(n);
        @(posedge clk); #1;

        // min negative minus one: signed overflow, no borrow
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_valid(n);
        @(posedge clk); #1;

        // equal operands subtract to zero
        send(32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_valid(n);
        @(posedge clk); #1;

        // max positive plus one: signed overflow
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_valid(n);
        @(posedge clk); #1;
        chk("idle_hold_sum",   out_sum,            32'h8000_0000);
        chk("idle_hold_ovf",   {31'b0, out_ovf},   32'd1);
        chk("idle_hold_valid", {31'b0, out_valid}, 32'd0);

        // backpressure, with a second request held on in_valid
        out_ready = 1'b0;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b1);
        in_a = 32'h1; in_b = 32'h1; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        sb.push_back('{sum: 32'h2, cout: 1'b0, zero: 1'b0, ovf: 1'b0});
        wait_valid(n);
        chk("latency_bp", n, 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_sum",   out_sum,            32'h2345_6789);
            chk("hold_ready", {31'b0, in_ready},  32'd0);
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_ready", {31'b0, in_ready}, 32'd1);
        chk("post_hs_busy",  {31'b0, busy},     32'd0);
        @(posedge clk); #1;
        chk("b2b_busy",  {31'b0, busy},     32'd1);
        chk("b2b_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        wait_valid(n);
        chk("latency_b2b", n, 32'd4);
        @(posedge clk); #1;

        // reset sampled on the edge of RUN step 2 aborts the operation
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy",  {31'b0, busy},      32'd0);
        chk("abort_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_sum",   out_sum,            32'd0);
        chk("abort_ready", {31'b0, in_ready},  32'd1);
        rst = 1'b0;
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid(n);
        @(posedge clk); #1;

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
